// File: rtl/ram_pkg.sv
// Shared types and helpers for the 1R1W init-swept register-array memory.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   ram_state_e     - sweep FSM state (RAM_INIT while zeroing, RAM_RUN afterwards)
//   RAM_MAX_W       - widest entry the mask expander supports
//   ram_addr_w      - address width for a given depth, never below 1
//   ram_expand_mask - widens a per-lane mask into a per-bit mask
package ram_pkg;

    typedef enum logic [0:0] {
        RAM_INIT = 1'b0,
        RAM_RUN  = 1'b1
    } ram_state_e;

    localparam int RAM_MAX_W  = 256;
    localparam int RAM_MAX_AW = 8;

    function automatic int ram_addr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // Bit i of the result copies lane bit (i / gran). Callers truncate the
    // result to their own WIDTH; bits above MASK_W*gran read zero lanes.
    function automatic logic [RAM_MAX_W-1:0] ram_expand_mask(
        input logic [RAM_MAX_W-1:0] mask,
        input int                   gran
    );
        logic [RAM_MAX_W-1:0] r_bits;
        int                   lane;
        r_bits = '0;
        for (int i = 0; i < RAM_MAX_W; i++) begin
            lane                    = i / gran;
            r_bits[i[RAM_MAX_AW-1:0]] = mask[lane[RAM_MAX_AW-1:0]];
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/ram_init_sweep.sv
// Post-reset sweep sequencer: walks entries 0..DEPTH-1 issuing zero writes, then parks in RUN.
// Latency: one entry per clock; o_init_done rises after exactly DEPTH edges following reset release.
// Backpressure: none; the sweep owns the write port while o_sweep_en is high.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset, restarts the sweep at entry 0
//   o_sweep_addr out  entry being zeroed this cycle
//   o_sweep_en   out  sweep write strobe (high throughout RAM_INIT)
//   o_init_done  out  high once every entry has been zeroed
module ram_init_sweep
    import ram_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] o_sweep_addr,
    output logic              o_sweep_en,
    output logic              o_init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        r_state;
    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RAM_INIT;
            r_cnt   <= '0;
        end else if (r_state == RAM_INIT) begin
            // The last entry is written on the same edge that enters RUN.
            if (r_cnt == LAST_ADDR) begin
                r_state <= RAM_RUN;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sweep_addr = r_cnt;
    assign o_sweep_en   = (r_state == RAM_INIT);
    assign o_init_done  = (r_state == RAM_RUN);

endmodule

// File: rtl/ram_1r1w_init.sv
// Single-clock 1R1W register-array memory with lane write masks, write-first bypass and post-reset zero sweep.
// Latency: write visible to reads issued next cycle; read data/valid registered, one cycle after R0_en.
// Backpressure: none; requests while init_done is low are dropped and must be retried by the requester.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   R0_addr/R0_en  read request; R0_data/R0_valid return it one cycle later
//   W0_addr/W0_en  write request; W0_data under per-lane W0_mask
//   init_done      sweep complete, requests accepted only while high
module ram_1r1w_init
    import ram_pkg::*;
#(
    parameter int  DEPTH     = 3,
    parameter int  WIDTH     = 1,
    parameter int  MASK_GRAN = 1,
    localparam int ADDR_W    = ram_addr_w(DEPTH),
    localparam int MASK_W    = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [MASK_W-1:0] W0_mask,
    output logic              init_done
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("ram_1r1w_init: DEPTH must be at least 2");
    end
    if (MASK_GRAN < 1 || (WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
        $error("ram_1r1w_init: WIDTH must be a whole multiple of MASK_GRAN");
    end
    if (WIDTH > RAM_MAX_W) begin : g_bad_width
        $error("ram_1r1w_init: WIDTH exceeds RAM_MAX_W");
    end

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Plain unpacked array, no reset, so an SRAM macro can be substituted.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [WIDTH-1:0]  r_rd_dat;
    logic              r_rd_vld;

    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_sweep_en;
    logic              w_init_done;
    logic [WIDTH-1:0]  w_bmask;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr;
    logic              w_rd;
    logic [WIDTH-1:0]  w_rd_old;
    logic [WIDTH-1:0]  w_rd_nxt;

    ram_init_sweep #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clock        (clock),
        .reset        (reset),
        .o_sweep_addr (w_sweep_addr),
        .o_sweep_en   (w_sweep_en),
        .o_init_done  (w_init_done)
    );

    assign w_bmask       = WIDTH'(ram_expand_mask(RAM_MAX_W'(W0_mask), MASK_GRAN));
    assign w_wr_in_range = ({1'b0, W0_addr} < DEPTH_C);
    assign w_rd_in_range = ({1'b0, R0_addr} < DEPTH_C);

    // Out-of-range writes are dropped here, which also keeps them out of the bypass.
    assign w_wr = w_init_done && W0_en && w_wr_in_range;
    assign w_rd = w_init_done && R0_en;

    // Storage write port: sweep owns it during INIT, W0 afterwards.
    always_ff @(posedge clock) begin
        if (w_sweep_en) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (w_wr) begin
            r_mem[W0_addr] <= (W0_data & w_bmask) | (r_mem[W0_addr] & ~w_bmask);
        end
    end

    // Next read value: zero when out of range, write-first merge on an address match.
    always_comb begin
        w_rd_old = '0;
        w_rd_nxt = '0;
        if (w_rd_in_range) begin
            w_rd_old = r_mem[R0_addr];
            if (w_wr && (W0_addr == R0_addr)) begin
                w_rd_nxt = (W0_data & w_bmask) | (w_rd_old & ~w_bmask);
            end else begin
                w_rd_nxt = w_rd_old;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd;
            if (w_rd) begin
                r_rd_dat <= w_rd_nxt;
            end
        end
    end

    assign R0_data   = r_rd_dat;
    assign R0_valid  = r_rd_vld;
    assign init_done = w_init_done;

endmodule

// File: tb/tb_ram_1r1w_init.sv
module tb_ram_1r1w_init;

    localparam int DEPTH     = 5;
    localparam int WIDTH     = 8;
    localparam int MASK_GRAN = 4;

    logic       clock;
    logic       reset;
    logic [2:0] R0_addr;
    logic       R0_en;
    logic [7:0] R0_data;
    logic       R0_valid;
    logic [2:0] W0_addr;
    logic       W0_en;
    logic [7:0] W0_data;
    logic [1:0] W0_mask;
    logic       init_done;

    int n_cmp;
    int n_err;

    ram_1r1w_init #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .MASK_GRAN (MASK_GRAN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .R0_addr   (R0_addr),
        .R0_en     (R0_en),
        .R0_data   (R0_data),
        .R0_valid  (R0_valid),
        .W0_addr   (W0_addr),
        .W0_en     (W0_en),
        .W0_data   (W0_data),
        .W0_mask   (W0_mask),
        .init_done (init_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [1:0] m);
        W0_addr = a;
        W0_data = d;
        W0_mask = m;
        W0_en   = 1'b1;
        tick();
        W0_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        R0_addr = a;
        R0_en   = 1'b1;
        tick();
        R0_en   = 1'b0;
        check({tag, "_data"}, 32'(R0_data), 32'(exp));
        check({tag, "_valid"}, 32'(R0_valid), 32'd1);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        R0_addr = '0;
        R0_en   = 1'b0;
        W0_addr = '0;
        W0_en   = 1'b0;
        W0_data = '0;
        W0_mask = '0;

        #2;
        check("rst_valid", 32'(R0_valid), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_data", 32'(R0_data), 32'd0);

        // Requests held during the whole sweep must be ignored.
        #10;
        reset   = 1'b0;
        W0_addr = 3'd0;
        W0_data = 8'h77;
        W0_mask = 2'b11;
        W0_en   = 1'b1;
        R0_addr = 3'd0;
        R0_en   = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            check($sformatf("sweep_done_e%0d", k), 32'(init_done), (k == DEPTH) ? 32'd1 : 32'd0);
            check($sformatf("sweep_valid_e%0d", k), 32'(R0_valid), 32'd0);
        end
        W0_en = 1'b0;
        R0_en = 1'b0;

        // Back-to-back reads of the freshly zeroed array.
        for (int a = 0; a < DEPTH; a++) begin
            rd($sformatf("zero_a%0d", a), 3'(a), 8'h00);
        end

        // Masked writes: 0xAB full, then 0xCD low lane only -> 0xAD.
        wr(3'd2, 8'hAB, 2'b11);
        wr(3'd2, 8'hCD, 2'b01);
        rd("mask_a2", 3'd2, 8'hAD);

        // Idle cycle: valid drops, data holds.
        wr(3'd4, 8'h99, 2'b00);
        check("idle_valid", 32'(R0_valid), 32'd0);
        check("idle_hold", 32'(R0_data), 32'hAD);
        rd("nomask_a4", 3'd4, 8'h00);

        // Write-first bypass with partial mask.
        wr(3'd1, 8'h11, 2'b11);
        W0_addr = 3'd1;
        W0_data = 8'h22;
        W0_mask = 2'b10;
        W0_en   = 1'b1;
        rd("bypass_a1", 3'd1, 8'h21);
        W0_en   = 1'b0;
        rd("after_bypass_a1", 3'd1, 8'h21);

        // Out-of-range address: dropped write, zero read, no bypass.
        wr(3'd6, 8'hFF, 2'b11);
        rd("oor_a6", 3'd6, 8'h00);
        W0_addr = 3'd6;
        W0_data = 8'hFF;
        W0_mask = 2'b11;
        W0_en   = 1'b1;
        rd("oor_bypass_a6", 3'd6, 8'h00);
        W0_en   = 1'b0;
        rd("oor_keep_a0", 3'd0, 8'h00);
        rd("oor_keep_a1", 3'd1, 8'h21);
        rd("oor_keep_a2", 3'd2, 8'hAD);
        rd("oor_keep_a3", 3'd3, 8'h00);
        rd("oor_keep_a4", 3'd4, 8'h00);

        // Reset in the middle of traffic.
        wr(3'd3, 8'h5A, 2'b11);
        rd("pre_rst_a3", 3'd3, 8'h5A);
        R0_addr = 3'd3;
        R0_en   = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(R0_valid), 32'd0);
        check("mid_rst_done", 32'(init_done), 32'd0);
        check("mid_rst_data", 32'(R0_data), 32'd0);
        #1;
        reset = 1'b0;
        R0_en = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            check($sformatf("resweep_done_e%0d", k), 32'(init_done), (k == DEPTH) ? 32'd1 : 32'd0);
        end
        rd("post_rst_a3", 3'd3, 8'h00);
        rd("post_rst_a2", 3'd2, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
